// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared line-memory constants, FSM state type and byte-merge helper
package mem_pkg;

    localparam int DEF_LINE_BITS = 512;
    localparam int DEF_DEPTH     = 128;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    function automatic logic [31:0] merge_word(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  byte_en
    );
        logic [31:0] merged;
        for (int k = 0; k < 4; k++) begin
            merged[k*8 +: 8] = byte_en[k] ? new_word[k*8 +: 8] : old_word[k*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/line_word_merge.sv
// rtl/line_word_merge.sv - combinational merge of a byte-enabled 32-bit word into a line
module line_word_merge
    import mem_pkg::*;
#(
    parameter int LINE_BITS = DEF_LINE_BITS
) (
    input  logic [LINE_BITS-1:0]              i_line,
    input  logic [31:0]                       i_word,
    input  logic [3:0]                        i_byte_en,
    input  logic [$clog2(LINE_BITS/32)-1:0]   i_word_idx,
    output logic [LINE_BITS-1:0]              o_line
);

    localparam int WORDS  = LINE_BITS / 32;
    localparam int WIDX_W = $clog2(WORDS);

    always_comb begin
        o_line = i_line;
        for (int w = 0; w < WORDS; w++) begin
            if (i_word_idx == WIDX_W'(w)) begin
                o_line[w*32 +: 32] = merge_word(i_line[w*32 +: 32], i_word, i_byte_en);
            end
        end
    end

endmodule

// File: rtl/line_memory.sv
// rtl/line_memory.sv - line-wide main memory model with fixed-latency request/response handshake
// Optional access counters are enabled with LINE_MEMORY_STATS_EN.
module line_memory
    import mem_pkg::*;
#(
    parameter int LINE_BITS = DEF_LINE_BITS,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int LATENCY   = 1,
    parameter int ADDR_BITS = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic                 req_full_line,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [31:0]          req_wword,
    input  logic [3:0]           req_byte_en,
    input  logic [LINE_BITS-1:0] req_wline,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_write,
    output logic                 resp_err,
    output logic [LINE_BITS-1:0] resp_rline
`ifdef LINE_MEMORY_STATS_EN
    ,
    output logic [31:0]          stat_reads,
    output logic [31:0]          stat_writes
`endif
);

    localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
    localparam int WIDX_W      = OFFSET_BITS - 2;
    localparam int IDX_W       = ADDR_BITS - OFFSET_BITS;
    localparam int MIDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W       = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_cnt;

    logic                   r_write;
    logic                   r_full;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [31:0]            r_wword;
    logic [3:0]             r_byte_en;
    logic [LINE_BITS-1:0]   r_wline;

    logic [LINE_BITS-1:0]   r_mem [DEPTH];

    logic [IDX_W-1:0]       w_idx;
    logic [MIDX_W-1:0]      w_midx;
    logic [WIDX_W-1:0]      w_word_idx;
    logic                   w_oor;
    logic                   w_accept;
    logic                   w_access;
    logic                   w_consume;
    logic                   w_do_write;
    logic [LINE_BITS-1:0]   w_old_line;
    logic [LINE_BITS-1:0]   w_merged_line;
    logic [LINE_BITS-1:0]   w_new_line;
    logic                   w_unused;

    // Decode works from the latched request so bus changes while busy are ignored.
    assign w_idx      = r_addr[ADDR_BITS-1:OFFSET_BITS];
    assign w_midx     = w_idx[MIDX_W-1:0];
    assign w_word_idx = r_addr[OFFSET_BITS-1:2];
    assign w_oor      = (w_idx >= IDX_W'(DEPTH));
    assign w_old_line = r_mem[w_midx];
    assign w_unused   = ^r_addr[1:0];

    line_word_merge #(
        .LINE_BITS (LINE_BITS)
    ) u_merge (
        .i_line     (w_old_line),
        .i_word     (r_wword),
        .i_byte_en  (r_byte_en),
        .i_word_idx (w_word_idx),
        .o_line     (w_merged_line)
    );

    assign w_new_line = r_full ? r_wline : w_merged_line;
    assign w_do_write = w_access && r_write && !w_oor && !reset;

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        w_accept     = 1'b0;
        w_access     = 1'b0;
        w_consume    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_access     = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    w_consume    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt      <= '0;
            resp_valid <= 1'b0;
            resp_write <= 1'b0;
            resp_err   <= 1'b0;
            resp_rline <= '0;
        end else begin
            if (w_accept) begin
                r_cnt <= CNT_W'(LATENCY - 1);
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_access) begin
                resp_valid <= 1'b1;
                resp_write <= r_write;
                resp_err   <= w_oor;
                resp_rline <= (r_write || w_oor) ? '0 : w_old_line;
            end else if (w_consume) begin
                resp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_write   <= req_write;
            r_full    <= req_full_line;
            r_addr    <= req_addr;
            r_wword   <= req_wword;
            r_byte_en <= req_byte_en;
            r_wline   <= req_wline;
        end
    end

    // Contents deliberately survive reset; only the in-flight write is suppressed.
    always_ff @(posedge clock) begin
        if (w_do_write) begin
            r_mem[w_midx] <= w_new_line;
        end
    end

`ifdef LINE_MEMORY_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_reads  <= '0;
            stat_writes <= '0;
        end else if (w_access) begin
            if (r_write) begin
                stat_writes <= stat_writes + 32'd1;
            end else begin
                stat_reads  <= stat_reads + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_line_memory.sv
// tb/tb_line_memory.sv - directed table-driven bench for line_memory at LATENCY 1 and 4
module tb_line_memory;

    localparam int LB    = 512;
    localparam int DEPTH = 128;

    typedef struct {
        logic            write;
        logic            full;
        logic [31:0]     addr;
        logic [31:0]     wword;
        logic [3:0]      be;
        logic [LB-1:0]   wline;
        logic            exp_err;
        logic [LB-1:0]   exp_rline;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic          req_full_line = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wword = '0;
    logic [3:0]    req_byte_en = '0;
    logic [LB-1:0] req_wline = '0;
    logic          resp_ready = 1'b1;

    logic          req_ready1, resp_valid1, resp_write1, resp_err1;
    logic [LB-1:0] resp_rline1;
    logic          req_ready4, resp_valid4, resp_write4, resp_err4;
    logic [LB-1:0] resp_rline4;
`ifdef LINE_MEMORY_STATS_EN
    logic [31:0]   stat_reads1, stat_writes1, stat_reads4, stat_writes4;
`endif

    int checks   = 0;
    int failures = 0;

    line_memory #(.LINE_BITS(LB), .DEPTH(DEPTH), .LATENCY(1), .ADDR_BITS(32)) u_dut1 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready1), .req_write(req_write),
        .req_full_line(req_full_line), .req_addr(req_addr), .req_wword(req_wword),
        .req_byte_en(req_byte_en), .req_wline(req_wline),
        .resp_valid(resp_valid1), .resp_ready(resp_ready), .resp_write(resp_write1),
        .resp_err(resp_err1), .resp_rline(resp_rline1)
`ifdef LINE_MEMORY_STATS_EN
        , .stat_reads(stat_reads1), .stat_writes(stat_writes1)
`endif
    );

    line_memory #(.LINE_BITS(LB), .DEPTH(DEPTH), .LATENCY(4), .ADDR_BITS(32)) u_dut4 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready4), .req_write(req_write),
        .req_full_line(req_full_line), .req_addr(req_addr), .req_wword(req_wword),
        .req_byte_en(req_byte_en), .req_wline(req_wline),
        .resp_valid(resp_valid4), .resp_ready(resp_ready), .resp_write(resp_write4),
        .resp_err(resp_err4), .resp_rline(resp_rline4)
`ifdef LINE_MEMORY_STATS_EN
        , .stat_reads(stat_reads4), .stat_writes(stat_writes4)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic full, input logic [31:0] addr,
                                input logic [31:0] wword, input logic [3:0] be,
                                input logic [LB-1:0] wline, input logic err,
                                input logic [LB-1:0] rline);
        vec_t v;
        v.write = wr; v.full = full; v.addr = addr; v.wword = wword; v.be = be;
        v.wline = wline; v.exp_err = err; v.exp_rline = rline;
        return v;
    endfunction

    task automatic check_reset_values(input string name);
        check({name, "/ready1"}, LB'(req_ready1), LB'(1));
        check({name, "/ready4"}, LB'(req_ready4), LB'(1));
        check({name, "/valid1"}, LB'(resp_valid1), LB'(0));
        check({name, "/valid4"}, LB'(resp_valid4), LB'(0));
        check({name, "/write1"}, LB'(resp_write1), LB'(0));
        check({name, "/write4"}, LB'(resp_write4), LB'(0));
        check({name, "/err1"}, LB'(resp_err1), LB'(0));
        check({name, "/err4"}, LB'(resp_err4), LB'(0));
        check({name, "/rline1"}, resp_rline1, '0);
        check({name, "/rline4"}, resp_rline4, '0);
    endtask

    task automatic drive_req(input vec_t v);
        req_write = v.write; req_full_line = v.full; req_addr = v.addr;
        req_wword = v.wword; req_byte_en = v.be; req_wline = v.wline;
        req_valid = 1'b1;
    endtask

    // Issues one request to both instances, measures latency and checks the response.
    task automatic run_req(input string name, input vec_t v);
        int lat1, lat4;
        logic [LB-1:0] rl1, rl4;
        logic e1, e4, w1, w4;
        lat1 = -1; lat4 = -1; rl1 = '0; rl4 = '0; e1 = 0; e4 = 0; w1 = 0; w4 = 0;
        drive_req(v);
        check({name, "/req_ready1"}, LB'(req_ready1), LB'(1));
        check({name, "/req_ready4"}, LB'(req_ready4), LB'(1));
        @(posedge clock); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clock); #1;
            if (lat1 < 0 && resp_valid1) begin
                lat1 = c; rl1 = resp_rline1; e1 = resp_err1; w1 = resp_write1;
            end
            if (lat4 < 0 && resp_valid4) begin
                lat4 = c; rl4 = resp_rline4; e4 = resp_err4; w4 = resp_write4;
            end
            if (lat1 >= 0 && lat4 >= 0) break;
        end
        @(posedge clock); #1;
        check({name, "/lat1"}, LB'(lat1), LB'(1));
        check({name, "/lat4"}, LB'(lat4), LB'(4));
        check({name, "/rline1"}, rl1, v.exp_rline);
        check({name, "/rline4"}, rl4, v.exp_rline);
        check({name, "/err1"}, LB'(e1), LB'(v.exp_err));
        check({name, "/err4"}, LB'(e4), LB'(v.exp_err));
        check({name, "/write1"}, LB'(w1), LB'(v.write));
        check({name, "/write4"}, LB'(w4), LB'(v.write));
    endtask

    vec_t          vecs[17];
    logic [LB-1:0] zero_line, l1a, l1b, l1c, pat, npat;

    initial begin
        bit seen;

        zero_line = '0;
        l1a = '0; l1a[63:32] = 32'hDEADBEEF;
        l1b = '0; l1b[63:32] = 32'hDE22BE44;
        l1c = l1b; l1c[511:480] = 32'hCAFEF00D;
        for (int i = 0; i < 16; i++) pat[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
        npat = ~pat;

        vecs[0]  = mk(0, 0, 32'h0000_0000, 32'h0,         4'h0, zero_line, 0, zero_line);
        vecs[1]  = mk(1, 0, 32'h0000_0044, 32'hDEADBEEF,  4'hF, zero_line, 0, zero_line);
        vecs[2]  = mk(0, 0, 32'h0000_0040, 32'h0,         4'h0, zero_line, 0, l1a);
        vecs[3]  = mk(1, 0, 32'h0000_0044, 32'h11223344,  4'h5, zero_line, 0, zero_line);
        vecs[4]  = mk(0, 0, 32'h0000_0040, 32'h0,         4'h0, zero_line, 0, l1b);
        vecs[5]  = mk(1, 1, 32'h0000_0080, 32'hFFFFFFFF,  4'h0, pat,       0, zero_line);
        vecs[6]  = mk(0, 0, 32'h0000_0080, 32'h0,         4'h0, zero_line, 0, pat);
        vecs[7]  = mk(0, 0, 32'h0000_0083, 32'h0,         4'h0, zero_line, 0, pat);
        vecs[8]  = mk(1, 0, 32'h0000_0048, 32'hFFFFFFFF,  4'h0, zero_line, 0, zero_line);
        vecs[9]  = mk(0, 0, 32'h0000_0040, 32'h0,         4'h0, zero_line, 0, l1b);
        vecs[10] = mk(0, 0, 32'h0000_2000, 32'h0,         4'h0, zero_line, 1, zero_line);
        vecs[11] = mk(1, 0, 32'h0000_2000, 32'h12345678,  4'hF, zero_line, 1, zero_line);
        vecs[12] = mk(0, 0, 32'h0000_0000, 32'h0,         4'h0, zero_line, 0, zero_line);
        vecs[13] = mk(1, 0, 32'h0000_007C, 32'hCAFEF00D,  4'hF, zero_line, 0, zero_line);
        vecs[14] = mk(0, 0, 32'h0000_0040, 32'h0,         4'h0, zero_line, 0, l1c);
        vecs[15] = mk(1, 1, 32'h0000_1FC0, 32'h0,         4'hF, npat,      0, zero_line);
        vecs[16] = mk(0, 0, 32'h0000_1FC0, 32'h0,         4'h0, zero_line, 0, npat);

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check_reset_values("reset");

        for (int i = 0; i < 17; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: response must hold while resp_ready is low.
        resp_ready = 1'b0;
        drive_req(mk(0, 0, 32'h0000_0080, 32'h0, 4'h0, zero_line, 0, pat));
        @(posedge clock); #1;
        req_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clock); #1;
            if (resp_valid4) begin
                seen = 1;
                break;
            end
        end
        check("hold/seen4", LB'(seen), LB'(1));
        for (int c = 0; c < 5; c++) begin
            req_addr = 32'h0000_0000;
            check($sformatf("hold%0d/valid1", c), LB'(resp_valid1), LB'(1));
            check($sformatf("hold%0d/valid4", c), LB'(resp_valid4), LB'(1));
            check($sformatf("hold%0d/rline1", c), resp_rline1, pat);
            check($sformatf("hold%0d/rline4", c), resp_rline4, pat);
            check($sformatf("hold%0d/ready1", c), LB'(req_ready1), LB'(0));
            check($sformatf("hold%0d/ready4", c), LB'(req_ready4), LB'(0));
            @(posedge clock); #1;
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        check("release/valid1", LB'(resp_valid1), LB'(0));
        check("release/valid4", LB'(resp_valid4), LB'(0));
        check("release/ready1", LB'(req_ready1), LB'(1));
        check("release/ready4", LB'(req_ready4), LB'(1));

        // Reset while a write to 0x100 is waiting: the write must be dropped.
        drive_req(mk(1, 1, 32'h0000_0100, 32'h0, 4'hF, pat, 0, zero_line));
        @(posedge clock); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_reset_values("midreset");
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            check($sformatf("postreset%0d/valid1", c), LB'(resp_valid1), LB'(0));
            check($sformatf("postreset%0d/valid4", c), LB'(resp_valid4), LB'(0));
        end
        run_req("after_reset_0x100", mk(0, 0, 32'h0000_0100, 32'h0, 4'h0, zero_line, 0, zero_line));
        run_req("after_reset_0x40", mk(0, 0, 32'h0000_0040, 32'h0, 4'h0, zero_line, 0, l1c));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
